// File: rtl/dac_stream_arbiter.sv
// Round-robin arbiter sharing one serial DAC between four sample streams,
// with one-deep per-channel buffering and a minimum beat spacing.
module dac_stream_arbiter #(
    parameter int DATA_W       = 12,
    parameter int ERR_W        = 2,
    parameter int FRAME_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sink_data_0,
    input  logic [DATA_W-1:0] sink_data_1,
    input  logic [DATA_W-1:0] sink_data_2,
    input  logic [DATA_W-1:0] sink_data_3,
    input  logic              sink_valid_0,
    input  logic              sink_valid_1,
    input  logic              sink_valid_2,
    input  logic              sink_valid_3,
    input  logic [ERR_W-1:0]  sink_error_0,
    input  logic [ERR_W-1:0]  sink_error_1,
    input  logic [ERR_W-1:0]  sink_error_2,
    input  logic [ERR_W-1:0]  sink_error_3,
    input  logic [3:0]        enable_mask,
    input  logic              overrun_clear,
    output logic [DATA_W-1:0] source_data,
    output logic              source_valid,
    output logic [ERR_W-1:0]  source_error,
    output logic [1:0]        source_channel,
    output logic [3:0]        overrun,
    output logic              busy
);
    typedef enum logic {IDLE, GUARD} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(FRAME_CYCLES - 1);

    logic [DATA_W-1:0] in_data [4];
    logic [ERR_W-1:0]  in_err  [4];
    logic [3:0]        in_valid;
    logic [3:0]        cap;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [3:0]        pend_q, pend_d;
    logic [3:0]        ovr_q, ovr_d;
    logic [3:0]        ovr_set;
    logic [DATA_W-1:0] hd_q [4];
    logic [DATA_W-1:0] hd_d [4];
    logic [ERR_W-1:0]  he_q [4];
    logic [ERR_W-1:0]  he_d [4];
    logic [DATA_W-1:0] sd_q, sd_d;
    logic [ERR_W-1:0]  se_q, se_d;
    logic [1:0]        sc_q, sc_d;
    logic              sv_q, sv_d;

    logic [3:0]        eff;
    logic [1:0]        gnt;
    logic [1:0]        idx;
    logic              fire;

    assign in_data[0] = sink_data_0;
    assign in_data[1] = sink_data_1;
    assign in_data[2] = sink_data_2;
    assign in_data[3] = sink_data_3;
    assign in_err[0]  = sink_error_0;
    assign in_err[1]  = sink_error_1;
    assign in_err[2]  = sink_error_2;
    assign in_err[3]  = sink_error_3;
    assign in_valid   = {sink_valid_3, sink_valid_2,
                         sink_valid_1, sink_valid_0};
    assign cap        = in_valid & enable_mask;

    // Walk from farthest to nearest so the nearest candidate wins.
    always_comb begin
        eff  = pend_q & enable_mask;
        gnt  = last_q + 2'd1;
        idx  = '0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + 2'(k);
            if (eff[idx]) gnt = idx;
        end
        fire = (state_q == IDLE) && (|eff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            pend_q  <= '0;
            ovr_q   <= '0;
            hd_q    <= '{default: '0};
            he_q    <= '{default: '0};
            sd_q    <= '0;
            se_q    <= '0;
            sc_q    <= '0;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            hd_q    <= hd_d;
            he_q    <= he_d;
            sd_q    <= sd_d;
            se_q    <= se_d;
            sc_q    <= sc_d;
            sv_q    <= sv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sv_d    = 1'b0;
        sd_d    = sd_q;
        se_d    = se_q;
        sc_d    = sc_q;
        pend_d  = pend_q;
        hd_d    = hd_q;
        he_d    = he_q;
        ovr_set = '0;

        if (fire) begin
            sv_d    = 1'b1;
            sd_d    = hd_q[gnt];
            se_d    = he_q[gnt];
            sc_d    = gnt;
            last_d  = gnt;
            cnt_d   = CNT_LOAD;
            state_d = GUARD;
        end else if (state_q == GUARD) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) state_d = IDLE;
        end

        // A capture on the grant edge refills the slot without an overrun.
        for (int i = 0; i < 4; i++) begin
            if (cap[i]) begin
                pend_d[i]  = 1'b1;
                hd_d[i]    = in_data[i];
                he_d[i]    = in_err[i];
                ovr_set[i] = pend_q[i] & ~(fire && gnt == 2'(i));
            end else if (!enable_mask[i]) begin
                pend_d[i] = 1'b0;
            end else if (fire && gnt == 2'(i)) begin
                pend_d[i] = 1'b0;
            end
        end

        ovr_d = (overrun_clear ? 4'b0 : ovr_q) | ovr_set;
    end

    assign source_data    = sd_q;
    assign source_valid   = sv_q;
    assign source_error   = se_q;
    assign source_channel = sc_q;
    assign overrun        = ovr_q;
    assign busy           = (state_q == GUARD);

endmodule

// File: tb/tb_dac_stream_arbiter.sv
// Self-checking bench for dac_stream_arbiter: directed scenarios plus
// randomized traffic against a cycle-count based reference model.
module tb_dac_stream_arbiter;
    localparam int DW = 12;
    localparam int EW = 2;
    localparam int FC = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] sd [4];
    logic [EW-1:0] se [4];
    logic [3:0]    sv;
    logic [3:0]    mask;
    logic          oclr;

    logic [DW-1:0] source_data;
    logic          source_valid;
    logic [EW-1:0] source_error;
    logic [1:0]    source_channel;
    logic [3:0]    overrun;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dac_stream_arbiter #(
        .DATA_W(DW), .ERR_W(EW), .FRAME_CYCLES(FC)
    ) dut (
        .clk(clk), .reset(reset),
        .sink_data_0(sd[0]), .sink_data_1(sd[1]),
        .sink_data_2(sd[2]), .sink_data_3(sd[3]),
        .sink_valid_0(sv[0]), .sink_valid_1(sv[1]),
        .sink_valid_2(sv[2]), .sink_valid_3(sv[3]),
        .sink_error_0(se[0]), .sink_error_1(se[1]),
        .sink_error_2(se[2]), .sink_error_3(se[3]),
        .enable_mask(mask), .overrun_clear(oclr),
        .source_data(source_data), .source_valid(source_valid),
        .source_error(source_error), .source_channel(source_channel),
        .overrun(overrun), .busy(busy)
    );

    // Reference model: beats are allowed once the cycle index reaches
    // the previous beat cycle plus FRAME_CYCLES.
    logic [3:0]    m_pend;
    logic [DW-1:0] m_hd [4];
    logic [EW-1:0] m_he [4];
    logic [3:0]    m_ovr;
    int            m_last;
    int            m_t = 0;
    int            m_ready = 0;
    logic          m_v;
    logic [DW-1:0] m_sd;
    logic [EW-1:0] m_se;
    logic [1:0]    m_sc;
    logic          m_busy;
    int            g;
    logic [3:0]    setb;

    initial forever begin
        @(posedge clk);
        m_t++;
        g = -1;
        setb = '0;
        m_v = 1'b0;
        if (reset) begin
            m_pend = '0; m_ovr = '0; m_last = 3;
            m_sd = '0; m_se = '0; m_sc = '0;
            m_ready = m_t; m_busy = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_hd[i] = '0; m_he[i] = '0;
            end
        end else begin
            if (m_t >= m_ready)
                for (int k = 1; k <= 4; k++)
                    if (g < 0 && m_pend[(m_last + k) % 4]
                        && mask[(m_last + k) % 4])
                        g = (m_last + k) % 4;
            if (g >= 0) begin
                m_v = 1'b1;
                m_sd = m_hd[g]; m_se = m_he[g]; m_sc = 2'(g);
                m_last = g;
                m_ready = m_t + FC;
            end
            m_busy = (m_t < m_ready - 1);
            for (int i = 0; i < 4; i++) begin
                if (sv[i] && mask[i]) begin
                    if (m_pend[i] && g != i) setb[i] = 1'b1;
                    m_pend[i] = 1'b1;
                    m_hd[i] = sd[i]; m_he[i] = se[i];
                end else if (!mask[i]) begin
                    m_pend[i] = 1'b0;
                end else if (g == i) begin
                    m_pend[i] = 1'b0;
                end
            end
            m_ovr = (oclr ? 4'b0 : m_ovr) | setb;
        end
    end

    task automatic idle_in();
        sv = '0;
        oclr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sd[i] = '0; se[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_in();
        mask = 4'hF;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        mask = 4'hF;
        oclr = 1'b0;
        sv = 4'hF;
        for (int i = 0; i < 4; i++) begin
            sd[i] = 12'hFFF; se[i] = 2'b11;
        end
        @(negedge clk);
        checks++;
        if (source_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %b want 0", source_valid); end
        checks++;
        if (source_data !== 12'h000) begin errors++;
            $display("FAIL reset_data got %h want 000", source_data); end
        checks++;
        if (source_error !== 2'b00) begin errors++;
            $display("FAIL reset_err got %b want 00", source_error); end
        checks++;
        if (source_channel !== 2'd0) begin errors++;
            $display("FAIL reset_chan got %0d want 0", source_channel); end
        checks++;
        if (overrun !== 4'h0) begin errors++;
            $display("FAIL reset_ovr got %b want 0000", overrun); end
        checks++;
        if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        idle_in();
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            checks++;
            if (source_valid !== 1'b0) begin errors++;
                $display("FAIL reset_nobeat j=%0d got 1 want 0", j); end
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        repeat (8) @(negedge clk);
        sv[2] = 1'b1; sd[2] = 12'hABC; se[2] = 2'b01;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (j == 1) idle_in();
            checks++;
            if (source_valid !== (j == 2)) begin errors++;
                $display("FAIL single_valid j=%0d got %b want %b",
                         j, source_valid, j == 2); end
            checks++;
            if (busy !== (j >= 2 && j <= 16)) begin errors++;
                $display("FAIL single_busy j=%0d got %b want %b",
                         j, busy, j >= 2 && j <= 16); end
            if (j == 2) begin
                checks++;
                if (source_data !== 12'hABC || source_channel !== 2'd2
                    || source_error !== 2'b01) begin errors++;
                    $display("FAIL single_beat got %h/%0d/%b want abc/2/01",
                             source_data, source_channel, source_error);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int bt[$];
        int bc[$];
        int bd[$];
        do_reset();
        for (int i = 0; i < 4; i++) sd[i] = 12'(i);
        sv = 4'hF;
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (source_valid) begin
                bt.push_back(j);
                bc.push_back(int'(source_channel));
                bd.push_back(int'(source_data));
            end
        end
        idle_in();
        checks++;
        if (bt.size() != 5) begin errors++;
            $display("FAIL rr_count got %0d want 5", bt.size()); end
        for (int b = 0; b < bt.size() && b < 5; b++) begin
            checks++;
            if (bt[b] != 2 + FC * b || bc[b] != b % 4 || bd[b] != b % 4)
            begin errors++;
                $display("FAIL rr_beat%0d got t=%0d ch=%0d d=%0d want t=%0d ch=%0d",
                         b, bt[b], bc[b], bd[b], 2 + FC * b, b % 4);
            end
        end
    endtask

    task automatic test_overwrite();
        int ch1_t;
        logic [DW-1:0] ch1_d;
        ch1_t = -1;
        ch1_d = '0;
        do_reset();
        sv[0] = 1'b1; sd[0] = 12'h0AA;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (source_valid && source_channel == 2'd1 && ch1_t < 0) begin
                ch1_t = j; ch1_d = source_data;
            end
            if (j == 19) begin
                checks++;
                if (overrun !== 4'b0010) begin errors++;
                    $display("FAIL ovr_set got %b want 0010", overrun); end
            end
            if (j == 21) begin
                checks++;
                if (overrun !== 4'b0000) begin errors++;
                    $display("FAIL ovr_clear got %b want 0000", overrun); end
            end
            if (j == 26) begin
                checks++;
                if (overrun !== 4'b0010) begin errors++;
                    $display("FAIL ovr_set_wins got %b want 0010", overrun); end
            end
            idle_in();
            if (j == 3)  begin sv[1] = 1'b1; sd[1] = 12'h111; end
            if (j == 5)  begin sv[1] = 1'b1; sd[1] = 12'h222; end
            if (j == 20) oclr = 1'b1;
            if (j == 24) begin sv[1] = 1'b1; sd[1] = 12'h333; end
            if (j == 25) begin
                sv[1] = 1'b1; sd[1] = 12'h344; oclr = 1'b1;
            end
        end
        idle_in();
        checks++;
        if (ch1_t != 18 || ch1_d !== 12'h222) begin errors++;
            $display("FAIL ovr_beat got t=%0d d=%h want t=18 d=222",
                     ch1_t, ch1_d); end
    endtask

    task automatic test_collision();
        int bt[$];
        int bd[$];
        do_reset();
        sv[3] = 1'b1; sd[3] = 12'h300;
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            if (source_valid) begin
                bt.push_back(j); bd.push_back(int'(source_data));
            end
            idle_in();
            if (j == 1) begin sv[3] = 1'b1; sd[3] = 12'h333; end
        end
        checks++;
        if (bt.size() != 2) begin errors++;
            $display("FAIL coll_count got %0d want 2", bt.size()); end
        else begin
            checks++;
            if (bt[0] != 2 || bd[0] != 'h300 || bt[1] != 18 || bd[1] != 'h333)
            begin errors++;
                $display("FAIL coll_beats got %0d:%h %0d:%h want 2:300 18:333",
                         bt[0], bd[0], bt[1], bd[1]);
            end
        end
        checks++;
        if (overrun !== 4'b0000) begin errors++;
            $display("FAIL coll_ovr got %b want 0000", overrun); end
    endtask

    task automatic test_mask();
        int nbeats;
        int nbad;
        nbeats = 0;
        nbad = 0;
        do_reset();
        sv[2] = 1'b1; sd[2] = 12'h222;
        for (int j = 1; j <= 45; j++) begin
            @(negedge clk);
            if (source_valid) begin
                nbeats++;
                if (source_channel != 2'd2) nbad++;
            end
            idle_in();
            if (j == 1)  begin sv[0] = 1'b1; sd[0] = 12'h0F0; end
            if (j == 5)  mask = 4'b1110;
            if (j == 8)  mask = 4'hF;
            if (j == 10) begin
                mask = 4'b0111; sv[3] = 1'b1; sd[3] = 12'h3F3;
            end
            if (j == 11) mask = 4'hF;
        end
        checks++;
        if (nbeats != 1 || nbad != 0) begin errors++;
            $display("FAIL mask_beats got %0d (%0d bad) want 1 (0 bad)",
                     nbeats, nbad); end
        checks++;
        if (overrun !== 4'b0000 || busy !== 1'b0) begin errors++;
            $display("FAIL mask_state got ovr=%b busy=%b want 0000/0",
                     overrun, busy); end
    endtask

    task automatic test_reset_guard();
        do_reset();
        sv[2] = 1'b1; sd[2] = 12'h5A5; se[2] = 2'b10;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            checks++;
            if (source_valid !== (j == 2 || j == 15)) begin errors++;
                $display("FAIL rg_valid j=%0d got %b want %b",
                         j, source_valid, j == 2 || j == 15); end
            if (j == 11) begin
                checks++;
                if (source_data !== 12'h000 || source_error !== 2'b00
                    || source_channel !== 2'd0 || overrun !== 4'h0
                    || busy !== 1'b0) begin errors++;
                    $display("FAIL rg_zero got %h/%b/%0d/%b/%b want all 0",
                             source_data, source_error, source_channel,
                             overrun, busy);
                end
            end
            if (j == 15) begin
                checks++;
                if (source_data !== 12'h777 || source_channel !== 2'd1)
                begin errors++;
                    $display("FAIL rg_beat got %h/%0d want 777/1",
                             source_data, source_channel); end
            end
            if (j == 16) begin
                checks++;
                if (busy !== 1'b1) begin errors++;
                    $display("FAIL rg_busy got %b want 1", busy); end
            end
            idle_in();
            if (j == 1)  begin sv[1] = 1'b1; sd[1] = 12'h111; end
            if (j == 10) reset = 1'b1;
            if (j == 11) reset = 1'b0;
            if (j == 13) begin sv[1] = 1'b1; sd[1] = 12'h777; end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (source_valid !== m_v || busy !== m_busy
                || overrun !== m_ovr) begin errors++;
                $display("FAIL rnd_ctl c=%0d got v=%b b=%b o=%b want v=%b b=%b o=%b",
                         c, source_valid, busy, overrun, m_v, m_busy, m_ovr);
            end
            checks++;
            if (source_data !== m_sd || source_error !== m_se
                || source_channel !== m_sc) begin errors++;
                $display("FAIL rnd_data c=%0d got %h/%b/%0d want %h/%b/%0d",
                         c, source_data, source_error, source_channel,
                         m_sd, m_se, m_sc);
            end
            for (int i = 0; i < 4; i++) begin
                sv[i] = ($urandom_range(0, 7) == 0);
                sd[i] = 12'($urandom);
                se[i] = 2'($urandom);
                mask[i] = ($urandom_range(0, 15) != 0);
            end
            oclr = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 499) == 0);
        end
        reset = 1'b0;
        idle_in();
    endtask

    initial begin
        reset = 1'b1;
        mask = 4'hF;
        idle_in();
        test_reset();
        test_single_beat();
        test_round_robin();
        test_overwrite();
        test_collision();
        test_mask();
        test_reset_guard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_stream_arbiter.md
Name:
dac_stream_arbiter

Overview:
Round-robin arbiter that shares the single serial DAC between four Avalon-ST style 12-bit sample sources, such as the raw ADC stream and the lowpass, bandpass and highpass filter outputs. It buffers one sample per channel and grants the DAC to one pending channel at a time. It enforces a minimum spacing of FRAME_CYCLES between output beats so the DAC serialiser is never overrun. Sits between the filter bank and dac_serial in the clk_20 domain, replacing the static select switcher when time-multiplexed output is wanted.

Parameters:
DATA_W, 12, sample width
ERR_W, 2, error sideband width
FRAME_CYCLES, 16, minimum clk cycles between successive source_valid pulses (DAC frame length); legal range 2..255

Ports:
clk  in  1  sample-domain clock (clk_20)
reset  in  1  synchronous, active-high reset
sink_data_0..3  in  DATA_W each  channel sample data
sink_valid_0..3  in  1 each  single-cycle valid strobe per channel
sink_error_0..3  in  ERR_W each  error sideband, captured with data
enable_mask  in  4  bit i=1 admits channel i
overrun_clear  in  1  clears overrun sticky bits
source_data  out  DATA_W  granted sample to DAC
source_valid  out  1  single-cycle beat strobe
source_error  out  ERR_W  error sideband of granted sample
source_channel  out  2  index of granted channel, valid with source_valid
overrun  out  4  sticky per-channel overwrite flags
busy  out  1  high while in GUARD

Behaviour:
- Reset (sync, active-high): pending[3:0]=0, holding regs=0, source_data=0, source_valid=0, source_error=0, source_channel=0, overrun=0, busy=0, state=IDLE, last_grant=3 (channel 0 has first priority). Reset asserted mid-GUARD aborts the guard; no beat is emitted in the reset cycle or the cycle after it.
- Capture: at the edge where sink_valid_i=1 and enable_mask[i]=1, the holding reg takes {data,error} and pending[i] is set. Valid with mask bit 0 is ignored.
- Overwrite: if pending[i] is already set and channel i is not granted at that same edge, the new sample replaces the old one and overrun[i] is set.
- Capture on the same edge as the grant of channel i: the old sample goes out, the new sample is captured, pending[i] stays 1, and overrun is not set.
- Mask drop: enable_mask[i]=0 clears pending[i] at the next edge, with no beat and no overrun.
- overrun_clear zeroes overrun. A set event in the same cycle wins for that bit.
- FSM states: IDLE and GUARD.
  - IDLE: if any pending bit is effective (pending & enable_mask), select the first one searching last_grant+1, +2, +3, +4 mod 4.
  - At that edge: register source_data/error/channel, pulse source_valid=1 for exactly one cycle, clear the granted pending bit, update last_grant, load guard counter with FRAME_CYCLES-1, go to GUARD.
  - GUARD: busy=1, counter decrements each cycle, return to IDLE when it reaches 0.
  - Result: source_valid pulses are at least FRAME_CYCLES cycles apart.
- Latency: sink_valid at cycle k sets pending at k+1. With the arbiter idle and no competitor, source_valid is seen in cycle k+2.
- When source_valid=0, source_data, source_error and source_channel hold their last granted values.
- With all four channels continuously pending, grants run 0,1,2,3,0,... with spacing FRAME_CYCLES.
- No arithmetic on data; widths pass through unchanged.

Test Plan:
- Reset then single beat: FRAME_CYCLES=16, mask=4'hF, ch2 data 12'hABC, err 2'b01 at cycle 10 -> source_valid=1 only in cycle 12 with data 12'hABC, channel 2, error 01; busy high cycles 12..26.
- Round-robin fairness: all four channels strobed every cycle with data 12'h000+i -> beat channels 0,1,2,3,0 at cycles t, t+16, t+32, t+48, t+64; no gaps.
- Overwrite: ch1 gets 12'h111 then 12'h222 while ch0 holds the grant in GUARD -> ch1 beat carries 12'h222, overrun=4'b0010. overrun_clear then returns 0. Simultaneous clear and new overwrite leaves bit 1 at 1.
- Grant/capture collision: ch3 strobes 12'h333 on the exact edge its previous sample 12'h300 is granted -> 12'h300 beat now and 12'h333 beat after guard; overrun[3]=0.
- Mask: ch0 pending, enable_mask[0] dropped before grant -> no ch0 beat, pending cleared, no overrun. Strobes on a masked channel are ignored.
- Reset mid-GUARD: reset at guard count 7 with ch1 pending -> all outputs 0 the next cycle and pending cleared. A fresh ch1 strobe after deassert yields a beat 2 cycles later with no residual guard delay.
